ps2_scan_rx: RTL and testbench

Receives PS/2 keyboard frames on the raw `ps2c`/`ps2d` pins. Each data byte is checked for parity and framing. Break/extended prefix bytes (0xE0, 0xF0) are packed together with the final code byte into a 32-bit scan word, which is presented on `x` with a one-cycle `flag` strobe. The block is the producer side of the `x`/`flag` interface consumed by `regNumber`, so a key release of code 0x16 arrives there as `32'h0000F016`.

---
 rtl/ps2_scan_rx.sv | 169 ++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 keyboard frame receiver packing prefix bytes into 32-bit scan words
module ps2_scan_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2c,
    input  logic        ps2d,
    output logic [31:0] x,
    output logic        flag,
    output logic        err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic          c_s1, c_s2, d_s1, d_s2;
    logic [FW-1:0] fcnt;
    logic          fc, fc_d;
    logic          fall;

    state_t        state_q, state_d;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          parbit;
    logic          par_ok;
    logic [TW-1:0] tcnt;
    logic [23:0]   acc;

    logic          load_start, shift_en, par_en, good, bad, tmo;

    // Both pins idle high, so synchronizers and filter come out of reset at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_s1 <= 1'b1;
            c_s2 <= 1'b1;
            d_s1 <= 1'b1;
            d_s2 <= 1'b1;
        end else begin
            c_s1 <= ps2c;
            c_s2 <= c_s1;
            d_s1 <= ps2d;
            d_s2 <= d_s1;
        end
    end

    // fc follows c_s2 only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            fc   <= 1'b1;
            fc_d <= 1'b1;
            fcnt <= '0;
        end else begin
            fc_d <= fc;
            if (c_s2 != fc) begin
                if (fcnt == FW'(FILTER_LEN - 1)) begin
                    fc   <= c_s2;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign fall   = fc_d & ~fc;
    assign par_ok = ^{shreg, parbit};

    always_comb begin
        state_d    = state_q;
        load_start = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        good       = 1'b0;
        bad        = 1'b0;
        tmo        = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall && !d_s2) begin
                    state_d    = DATA;
                    load_start = 1'b1;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_en = 1'b1;
                    if (bitcnt == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_en  = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (d_s2 && par_ok) good = 1'b1;
                    else                bad  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A bit arriving in the same cycle wins over an expiring timer.
        if (state_q != IDLE && !fall && tcnt >= TW'(TIMEOUT_CYCLES - 1)) begin
            state_d    = IDLE;
            load_start = 1'b0;
            tmo        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bitcnt  <= '0;
            shreg   <= '0;
            parbit  <= 1'b0;
            tcnt    <= '0;
            acc     <= '0;
            x       <= '0;
            flag    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            flag    <= 1'b0;
            err     <= 1'b0;

            if (state_q == IDLE || fall)
                tcnt <= '0;
            else if (tcnt != TW'(TIMEOUT_CYCLES))
                tcnt <= tcnt + TW'(1);

            if (load_start)
                bitcnt <= '0;
            if (shift_en) begin
                shreg  <= {d_s2, shreg[7:1]};
                bitcnt <= bitcnt + 3'd1;
            end
            if (par_en)
                parbit <= d_s2;

            if (good) begin
                if (shreg == 8'hE0 || shreg == 8'hF0) begin
                    acc <= {acc[15:0], shreg};
                end else begin
                    x    <= {acc, shreg};
                    flag <= 1'b1;
                    acc  <= '0;
                end
            end
            if (bad || tmo) begin
                err <= 1'b1;
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb/tb_ps2_scan_rx.sv - scoreboard bench for ps2_scan_rx
module tb_ps2_scan_rx;

    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2c;
    logic        ps2d;
    logic [31:0] x;
    logic        flag;
    logic        err;

    ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .ps2c  (ps2c),
        .ps2d  (ps2d),
        .x     (x),
        .flag  (flag),
        .err   (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [31:0] xv;
        bit          chk_lat;
    } exp_t;

    exp_t        q[$];
    int          compared   = 0;
    int          mismatched = 0;
    int unsigned stop_cyc   = 0;
    logic [31:0] last_x     = '0;
    bit          prev_flag  = 1'b0;
    bit          mon_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_err, input logic [31:0] xv, input bit chk_lat);
        exp_t e;
        e.is_err  = is_err;
        e.xv      = xv;
        e.chk_lat = chk_lat;
        q.push_back(e);
    endtask

    // Data wiggles while the clock is high to prove it is ignored there.
    task automatic send_bit(input logic b);
        ps2d = ~b;
        tick(HALF / 2);
        ps2d = b;
        tick(HALF / 2);
        ps2c = 1'b0;
        stop_cyc = cyc;
        tick(HALF);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ flip_par);
        send_bit(1'b1);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(b[i]);
    endtask

    always @(negedge clk) begin
        if (!reset && mon_en) begin
            if (flag && err) begin
                compared++;
                mismatched++;
                $display("FAIL flag_err_overlap: flag=%b err=%b required not both", flag, err);
            end
            if (flag && prev_flag) begin
                compared++;
                mismatched++;
                $display("FAIL flag_width: flag high %0d cycles, required 1", 2);
            end
            if (flag || err) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_event: flag=%b err=%b x=%h, required none", flag, err, x);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("event_kind_err", {31'd0, err}, {31'd0, e.is_err});
                    if (flag && !e.is_err) check("scan_word", x, e.xv);
                    if (e.chk_lat) check("latency", cyc - stop_cyc, FL + 3);
                end
            end
            if (!flag && x !== last_x) begin
                compared++;
                mismatched++;
                $display("FAIL x_stable: x changed to %h without flag, required %h", x, last_x);
            end
            last_x    = x;
            prev_flag = flag;
        end
    end

    initial begin
        reset = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        tick(5);
        check("reset_x", x, 32'h0);
        check("reset_flag", {31'd0, flag}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        tick(2);
        last_x = '0;
        mon_en = 1'b1;

        // make code
        push(1'b0, 32'h00000016, 1'b1);
        send_frame(8'h16, 1'b0);

        // break codes
        send_frame(8'hF0, 1'b0);
        push(1'b0, 32'h0000F016, 1'b1);
        send_frame(8'h16, 1'b0);
        send_frame(8'hF0, 1'b0);
        push(1'b0, 32'h0000F014, 1'b1);
        send_frame(8'h14, 1'b0);

        // extended break
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        push(1'b0, 32'h00E0F075, 1'b1);
        send_frame(8'h75, 1'b0);

        // parity error drops the pending prefix
        push(1'b1, 32'h0, 1'b1);
        send_frame(8'hF0, 1'b1);
        push(1'b0, 32'h00000016, 1'b1);
        send_frame(8'h16, 1'b0);

        // timeout after 4 data bits
        push(1'b1, 32'h0, 1'b0);
        send_partial(8'h55, 4);
        tick(TO + 200);
        push(1'b0, 32'h0000001C, 1'b1);
        send_frame(8'h1C, 1'b0);

        // short glitch with data low must not look like a start bit
        tick(20);
        ps2d = 1'b0;
        ps2c = 1'b0;
        tick(3);
        ps2c = 1'b1;
        ps2d = 1'b1;
        tick(50);
        push(1'b0, 32'h00000016, 1'b1);
        send_frame(8'h16, 1'b0);

        // reset mid-frame after a prefix
        send_frame(8'hF0, 1'b0);
        send_partial(8'h16, 3);
        mon_en = 1'b0;
        reset  = 1'b1;
        tick(2);
        check("midreset_x", x, 32'h0);
        check("midreset_flag", {31'd0, flag}, 32'd0);
        check("midreset_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        tick(1);
        last_x    = '0;
        prev_flag = 1'b0;
        mon_en    = 1'b1;
        tick(100);
        push(1'b0, 32'h00000016, 1'b1);
        send_frame(8'h16, 1'b0);

        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        check("drain", q.size(), 32'd0);
        tick(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
